// File: rtl/unsigned_product_accumulator.sv
// -----------------------------------------------------------------------------
// unsigned_product_accumulator
//
// Purpose: sums a burst of unsigned products (terminated by prod_last) and
// presents the total, the number of beats and an overflow flag on a
// valid/ready result port. Feeds from the 5x5 multiplier product stream.
//
// Optional build macro: UNSIGNED_PRODUCT_ACCUMULATOR_SATURATE_EN
//   defined   : on carry-out the accumulator clamps to all-ones for the rest
//               of the burst
//   undefined : the accumulator wraps modulo 2^ACC_W
//   result_overflow is a sticky carry-out flag in both builds.
//
// Ports:
//   clock0           in   sole clock, rising edge
//   global_resetn    in   asynchronous active-low reset
//   acc_clear        in   synchronous abort/clear, beats highest priority
//   prod_valid       in   product beat valid
//   prod_ready       out  block can accept a beat (0 while holding a result)
//   prod_data        in   [PROD_W-1:0] unsigned product
//   prod_last        in   final beat of a burst
//   result_valid     out  total available
//   result_ready     in   consumer takes total
//   result_data      out  [ACC_W-1:0] accumulated sum
//   result_count     out  [COUNT_W-1:0] beats in burst (saturating)
//   result_overflow  out  sum exceeded 2^ACC_W-1 during the burst
//
// State | meaning
// ------+---------------------------------------------
// IDLE  | no beat of the current burst taken yet
// ACCUM | at least one beat taken, waiting for last
// HOLD  | result presented, waiting for result_ready
// -----------------------------------------------------------------------------
module unsigned_product_accumulator #(
    parameter int PROD_W  = 10,
    parameter int ACC_W   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clock0,
    input  logic               global_resetn,
    input  logic               acc_clear,
    input  logic               prod_valid,
    output logic               prod_ready,
    input  logic [PROD_W-1:0]  prod_data,
    input  logic               prod_last,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [ACC_W-1:0]   result_data,
    output logic [COUNT_W-1:0] result_count,
    output logic               result_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   rdata_q, rdata_d;
    logic [COUNT_W-1:0] rcnt_q, rcnt_d;
    logic               rovf_q, rovf_d;

    logic               beat_accept;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;
    logic [COUNT_W-1:0] cnt_next;
    logic               ovf_next;

    assign prod_ready  = (state_q != HOLD);
    assign beat_accept = prod_valid && prod_ready;

    // One extra bit so the carry-out of this beat is visible.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
    assign carry   = sum_ext[ACC_W];

`ifdef UNSIGNED_PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, stay clamped until the burst ends, even for zero beats.
    assign acc_next = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    assign ovf_next = ovf_q || carry;
    assign cnt_next = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        rcnt_d  = rcnt_q;
        rovf_d  = rovf_q;

        if (acc_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            rdata_d = '0;
            rcnt_d  = '0;
            rovf_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_accept) begin
                        acc_d = acc_next;
                        cnt_d = cnt_next;
                        ovf_d = ovf_next;
                        if (prod_last) begin
                            state_d = HOLD;
                            rdata_d = acc_next;
                            rcnt_d  = cnt_next;
                            rovf_d  = ovf_next;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        rdata_d = '0;
                        rcnt_d  = '0;
                        rovf_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    rdata_d = '0;
                    rcnt_d  = '0;
                    rovf_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock0 or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            rcnt_q  <= '0;
            rovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            rcnt_q  <= rcnt_d;
            rovf_q  <= rovf_d;
        end
    end

    assign result_valid    = (state_q == HOLD);
    assign result_data     = rdata_q;
    assign result_count    = rcnt_q;
    assign result_overflow = rovf_q;

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
module tb_unsigned_product_accumulator;

    localparam int PROD_W  = 10;
    localparam int ACC_W   = 16;
    localparam int COUNT_W = 8;

    logic               clock0;
    logic               global_resetn;
    logic               acc_clear;
    logic               prod_valid;
    logic               prod_ready;
    logic [PROD_W-1:0]  prod_data;
    logic               prod_last;
    logic               result_valid;
    logic               result_ready;
    logic [ACC_W-1:0]   result_data;
    logic [COUNT_W-1:0] result_count;
    logic               result_overflow;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];

    unsigned_product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .COUNT_W(COUNT_W)
    ) dut (
        .clock0         (clock0),
        .global_resetn  (global_resetn),
        .acc_clear      (acc_clear),
        .prod_valid     (prod_valid),
        .prod_ready     (prod_ready),
        .prod_data      (prod_data),
        .prod_last      (prod_last),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_data    (result_data),
        .result_count   (result_count),
        .result_overflow(result_overflow)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rvalid"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_rdata"}, {16'd0, result_data}, 32'd0);
        check({tag, "_rcount"}, {24'd0, result_count}, 32'd0);
        check({tag, "_rovf"}, {31'd0, result_overflow}, 32'd0);
        check({tag, "_pready"}, {31'd0, prod_ready}, 32'd1);
    endtask

    // Reference: sum of the whole burst as a plain integer.
    function automatic longint ref_total();
        longint t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    function automatic int ref_data();
        longint t = ref_total();
`ifdef UNSIGNED_PRODUCT_ACCUMULATOR_SATURATE_EN
        return (t > 65535) ? 65535 : int'(t);
`else
        return int'(t % 65536);
`endif
    endfunction

    function automatic int ref_count();
        return (q.size() > 255) ? 255 : q.size();
    endfunction

    function automatic int ref_ovf();
        return (ref_total() > 65535) ? 1 : 0;
    endfunction

    // Sends every beat of q (last flag on the final one), then checks the
    // held result for ready_delay cycles and performs the handshake.
    task automatic run_burst(input string tag, input int ready_delay, input int gap_max);
        int exp_d, exp_c, exp_o;
        exp_d = ref_data();
        exp_c = ref_count();
        exp_o = ref_ovf();
        foreach (q[i]) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max)) begin
                    prod_valid = 1'b0;
                    prod_data  = PROD_W'($urandom);
                    prod_last  = 1'b1;
                    tick();
                end
            end
            if (i == 0 || i == q.size() - 1)
                check({tag, "_pready_in"}, {31'd0, prod_ready}, 32'd1);
            prod_valid = 1'b1;
            prod_data  = PROD_W'(q[i]);
            prod_last  = (i == q.size() - 1);
            tick();
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check({tag, "_rvalid"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_rdata"}, {16'd0, result_data}, exp_d);
        check({tag, "_rcount"}, {24'd0, result_count}, exp_c);
        check({tag, "_rovf"}, {31'd0, result_overflow}, exp_o);
        check({tag, "_pready_hold"}, {31'd0, prod_ready}, 32'd0);
        for (int k = 0; k < ready_delay; k++) begin
            prod_valid = 1'b1;
            prod_data  = PROD_W'($urandom);
            tick();
            check({tag, "_hold_rvalid"}, {31'd0, result_valid}, 32'd1);
            check({tag, "_hold_rdata"}, {16'd0, result_data}, exp_d);
            check({tag, "_hold_rcount"}, {24'd0, result_count}, exp_c);
            check({tag, "_hold_pready"}, {31'd0, prod_ready}, 32'd0);
        end
        prod_valid   = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle({tag, "_post"});
    endtask

    initial begin
        global_resetn = 1'b0;
        acc_clear     = 1'b0;
        prod_valid    = 1'b0;
        prod_data     = '0;
        prod_last     = 1'b0;
        result_ready  = 1'b0;
        #12;
        check_idle("reset");
        global_resetn = 1'b1;
        tick();
        check_idle("after_reset");

        // Mixed burst including a zero-valued beat.
        q = '{35, 961, 0, 12};
        run_burst("burst4", 0, 0);

        // Single-beat burst, consumer stalls five cycles.
        q = '{961};
        run_burst("single", 5, 0);

        // Wrap / saturate: 69 x 961 = 66309.
        q.delete();
        repeat (69) q.push_back(961);
        run_burst("ovf69", 0, 0);

        // acc_clear drops a same-cycle beat and empties the accumulator.
        q = '{100, 100, 100};
        foreach (q[i]) begin
            prod_valid = 1'b1;
            prod_data  = PROD_W'(q[i]);
            prod_last  = 1'b0;
            tick();
        end
        acc_clear  = 1'b1;
        prod_valid = 1'b1;
        prod_data  = PROD_W'(50);
        tick();
        acc_clear  = 1'b0;
        prod_valid = 1'b0;
        check_idle("clear");
        q = '{7, 9};
        run_burst("after_clear", 0, 0);

        // acc_clear discards a held result.
        q = '{5};
        prod_valid = 1'b1;
        prod_data  = PROD_W'(5);
        prod_last  = 1'b1;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("clr_hold_rvalid", {31'd0, result_valid}, 32'd1);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check_idle("clear_hold");

        // Asynchronous reset while accumulating (sum 500).
        prod_valid = 1'b1;
        prod_last  = 1'b0;
        prod_data  = PROD_W'(200);
        tick();
        prod_data  = PROD_W'(300);
        tick();
        prod_valid = 1'b0;
        #2 global_resetn = 1'b0;
        #1 check_idle("arst_accum");
        #1 global_resetn = 1'b1;
        tick();

        // Asynchronous reset while holding a result.
        prod_valid = 1'b1;
        prod_data  = PROD_W'(400);
        prod_last  = 1'b1;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("arst_hold_pre_rvalid", {31'd0, result_valid}, 32'd1);
        #2 global_resetn = 1'b0;
        #1 check_idle("arst_hold");
        #1 global_resetn = 1'b1;
        tick();
        q = '{20, 22};
        run_burst("after_arst", 0, 0);

        // Beat counter saturation: 300 beats of 1.
        q.delete();
        repeat (300) q.push_back(1);
        run_burst("cnt_sat", 0, 0);

        // Randomized bursts of multiplier products with stalls and gaps.
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(1, 90);
            q.delete();
            for (int i = 0; i < len; i++)
                q.push_back($urandom_range(31) * $urandom_range(31));
            run_burst($sformatf("rand%0d", b), $urandom_range(3), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
